// File: rtl/countdown_if.sv
// Handshake bundle between the accelerator controller (master) and countdown_sequencer (slave).
interface countdown_if #(
   parameter int W = 4
);
   logic         START;
   logic [W-1:0] LOAD_VAL;
   logic         EN;
   logic         ABORT;
   logic         BUSY;
   logic         DONE;
   logic [W-1:0] Dout;

   modport master (
      output START, LOAD_VAL, EN, ABORT,
      input  BUSY, DONE, Dout
   );

   modport slave (
      input  START, LOAD_VAL, EN, ABORT,
      output BUSY, DONE, Dout
   );
endinterface

// File: rtl/countdown_sequencer.sv
// Loadable down-counter with START/BUSY/DONE handshake for timing fixed-length phases.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN for periodic reload from FIN.
module countdown_sequencer #(
   parameter int W = 4
) (
   input  logic       CLK,
   input  logic       RST,
   countdown_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN
   } state_e;

   state_e       state_q, state_d;
   logic [W-1:0] dout_q, dout_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [W-1:0] period_q, period_d;
`endif

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_d = state_q;
      dout_d  = dout_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      period_d = period_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (bus.START && !bus.ABORT) begin
               dout_d = bus.LOAD_VAL;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
               period_d = bus.LOAD_VAL;
`endif
               state_d = (bus.LOAD_VAL == '0) ? S_FIN : S_RUN;
            end
         end
         S_RUN: begin
            if (bus.ABORT) begin
               dout_d  = '0;
               state_d = S_IDLE;
            end else if (bus.EN) begin
               // Stop at zero rather than wrapping, even if a zero count ever reaches RUN.
               if (dout_q > W'(1)) begin
                  dout_d = dout_q - W'(1);
               end else begin
                  dout_d  = '0;
                  state_d = S_FIN;
               end
            end
         end
         S_FIN: begin
            dout_d  = '0;
            state_d = S_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (!bus.ABORT && (period_q != '0)) begin
               dout_d  = period_q;
               state_d = S_RUN;
            end
`endif
         end
         default: begin
            dout_d  = '0;
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they are registered yet align with it.
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FIN);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         dout_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         period_q <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so all flops update from pre-edge values.
         state_q <= state_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         period_q <= period_d;
`endif
      end
   end

   assign bus.BUSY = busy_q;
   assign bus.DONE = done_q;
   assign bus.Dout = dout_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench for countdown_sequencer: the driver predicts DONE edges from the EN
// sequence it will apply; a separate monitor checks every DONE pulse against that queue.
module tb_countdown_sequencer;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   countdown_if #(.W(W)) bus ();
   countdown_sequencer #(.W(W)) dut (.CLK(clk), .RST(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: every DONE pulse must match the oldest predicted edge.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (exp_q.size() > 0 && exp_q[0] < cyc) begin
            check("done_missed", cyc, exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (bus.DONE !== 1'b0) begin
            if (exp_q.size() == 0) begin
               check("done_unexpected", bus.DONE, 0);
            end else begin
               check("done_cycle", cyc, exp_q.pop_front());
               check("done_dout", bus.Dout, 0);
            end
         end
      end
   end

   // One countdown: n = length, abort_sel = -1 none, -2 random, >=0 run-edge index.
   task automatic do_run(input int n, input bit rand_en, input int stall_at, input int abort_sel);
      bit en_seq[$];
      int ones    = 0;
      int len;
      int abort_j = -1;
      int load_edge;
      int enc     = 0;
      while (ones < n) begin
         bit b;
         if (stall_at >= 0 && (en_seq.size() == stall_at || en_seq.size() == stall_at + 1))
            b = 1'b0;
         else if (rand_en)
            b = ($urandom_range(3) != 0);
         else
            b = 1'b1;
         en_seq.push_back(b);
         if (b) ones++;
      end
      len = en_seq.size();
      if (abort_sel >= 0 && abort_sel < len) abort_j = abort_sel;
      else if (abort_sel == -2 && len > 0) abort_j = $urandom_range(len - 1);

      // DONE shows after the edge that consumes the n-th enabled cycle.
      load_edge = cyc + 1;
      if (abort_j < 0) exp_q.push_back(load_edge + len);

      bus.START    = 1'b1;
      bus.LOAD_VAL = W'(n);
      bus.ABORT    = 1'b0;
      bus.EN       = 1'($urandom_range(1));
      tick();
      check("load_dout", bus.Dout, n);
      check("load_busy", bus.BUSY, 1);

      for (int j = 0; j < len; j++) begin
         bus.EN       = en_seq[j];
         bus.ABORT    = (j == abort_j);
         bus.START    = 1'($urandom_range(1));
         bus.LOAD_VAL = W'($urandom);
         tick();
         if (en_seq[j]) enc++;
         if (j == abort_j) begin
            check("abort_dout", bus.Dout, 0);
            check("abort_busy", bus.BUSY, 0);
            break;
         end
         check("run_dout", bus.Dout, n - enc);
         check("run_busy", bus.BUSY, 1);
      end

      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      if (abort_j < 0) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         bus.ABORT = 1'b1;
`endif
         tick();
         bus.ABORT = 1'b0;
         check("end_busy", bus.BUSY, 0);
         check("end_dout", bus.Dout, 0);
      end

      repeat ($urandom_range(2)) begin
         bus.EN = 1'($urandom_range(1));
         tick();
         check("idle_dout", bus.Dout, 0);
         check("idle_busy", bus.BUSY, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int load_edge;
      rst          = 1'b0;
      bus.START    = 1'b0;
      bus.LOAD_VAL = '0;
      bus.EN       = 1'b0;
      bus.ABORT    = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_dout", bus.Dout, 0);
      check("reset_busy", bus.BUSY, 0);
      check("reset_done", bus.DONE, 0);
      rst = 1'b1;
      tick();

      do_run(3, 1'b0, -1, -1);   // basic: 3,2,1,0 then DONE
      do_run(2, 1'b0, 1, -1);    // EN low for two cycles mid-run
      do_run(0, 1'b0, -1, -1);   // zero length: DONE right after load
      do_run(4, 1'b0, -1, 2);    // abort while Dout shows 2

      // START together with ABORT in IDLE must be ignored.
      bus.START    = 1'b1;
      bus.ABORT    = 1'b1;
      bus.LOAD_VAL = W'(7);
      tick();
      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      check("start_abort_busy", bus.BUSY, 0);
      check("start_abort_dout", bus.Dout, 0);
      tick();

      // Asynchronous reset in the middle of a count of 5.
      bus.START    = 1'b1;
      bus.LOAD_VAL = W'(5);
      bus.EN       = 1'b0;
      tick();
      bus.START = 1'b0;
      check("pre_reset_dout", bus.Dout, 5);
      #2 rst = 1'b0;
      #1;
      check("async_rst_dout", bus.Dout, 0);
      check("async_rst_busy", bus.BUSY, 0);
      check("async_rst_done", bus.DONE, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
      // Period 2 with EN high: DONE every 3 edges until ABORT.
      load_edge = cyc + 1;
      for (int k = 0; k < 3; k++) exp_q.push_back(load_edge + 2 + 3 * k);
      bus.START    = 1'b1;
      bus.LOAD_VAL = W'(2);
      bus.EN       = 1'b1;
      tick();
      bus.START = 1'b0;
      repeat (8) begin
         tick();
         check("reload_busy", bus.BUSY, 1);
      end
      check("reload_fin_dout", bus.Dout, 0);
      bus.ABORT = 1'b1;
      tick();
      bus.ABORT = 1'b0;
      check("reload_abort_busy", bus.BUSY, 0);
      repeat (4) tick();
`else
      load_edge = 0;
`endif

      for (int r = 0; r < 40; r++) begin
         do_run($urandom_range(15), 1'b1, -1, ($urandom_range(3) == 0) ? -2 : -1);
      end

      repeat (3) tick();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
